// File: rtl/out_port.sv
// out_port: output port on the 8-bit CPU datapath.
//
// The controller pulses outload on an OUT instruction; the accumulator byte
// on din is captured into a DEPTH-entry FIFO. Queued bytes are delivered to an
// external peripheral over a valid/ready handshake. full lets the controller
// stall further OUT instructions.
//
// Optional feature macro: OUTPORT_OVF_EN
//   When defined, adds the ovf/clrovf ports. ovf is a sticky flag recording a
//   push attempted while full. When undefined, dropped pushes are silent.
//
// Ports:
//   clk      in   clock, all state changes on posedge
//   rst      in   asynchronous active-low reset
//   din      in   [7:0] byte from the accumulator
//   outload  in   push strobe from the controller
//   dout     out  [7:0] head-of-queue byte
//   dvalid   out  dout holds a valid byte
//   dready   in   peripheral accepts dout this cycle
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  [AW:0] occupied entries, 0..DEPTH
//   ovf      out  sticky overflow (OUTPORT_OVF_EN only)
//   clrovf   in   clears ovf, set wins on collision (OUTPORT_OVF_EN only)
//
// Handshake: a byte transfers at a posedge where dvalid && dready are both
// high. While dvalid is high, dout and dvalid hold until that transfer;
// pushes write only at the tail and never touch the head entry.

module out_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    din,
  input  logic          outload,
  output logic [7:0]    dout,
  output logic          dvalid,
  input  logic          dready,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
`ifdef OUTPORT_OVF_EN
  ,
  output logic          ovf,
  input  logic          clrovf
`endif
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;

  // Status comes from the registered count, so a push attempted while full is
  // dropped even if a pop frees a slot at the same edge.
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign dvalid = !empty;
  assign dout   = mem[rp];

  assign push = outload && !full;
  assign pop  = dvalid && dready;

  // Storage is cleared on reset so dout reads 0 straight after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wp] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef OUTPORT_OVF_EN
  // Set has priority over clear so an overflow in the clearing cycle is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (outload && full) begin
      ovf <= 1'b1;
    end else if (clrovf) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_out_port.sv
// Testbench for out_port: scenario tasks with inline checks against a
// queue-based reference model of a bounded FIFO.

module tb_out_port;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst;
  logic [7:0]    din;
  logic          outload;
  logic [7:0]    dout;
  logic          dvalid;
  logic          dready;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          clrovf;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents of the queue and the sticky overflow flag.
  logic [7:0] exp_q[$];
  logic       exp_ovf;

  out_port #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .outload (outload),
    .dout    (dout),
    .dvalid  (dvalid),
    .dready  (dready),
    .full    (full),
    .empty   (empty),
    .count   (count)
`ifdef OUTPORT_OVF_EN
    ,
    .ovf     (ovf),
    .clrovf  (clrovf)
`endif
  );

`ifndef OUTPORT_OVF_EN
  assign ovf = 1'b0;
`endif

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply inputs at negedge, advance the model at the posedge,
  // return 1 time unit after the edge for sampling.
  task automatic step(input logic ol, input logic [7:0] d, input logic dr,
                      input logic co);
    bit was_full;
    bit do_pop;
    bit do_push;
    @(negedge clk);
    outload = ol;
    din     = d;
    dready  = dr;
    clrovf  = co;
    @(posedge clk);
    was_full = (exp_q.size() == DEPTH);
    do_pop   = (exp_q.size() > 0) && dr;
    do_push  = ol && !was_full;
`ifdef OUTPORT_OVF_EN
    if (ol && was_full) exp_ovf = 1'b1;
    else if (co)        exp_ovf = 1'b0;
`endif
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = '0; outload = 1'b0; dready = 1'b0; clrovf = 1'b0;
    exp_q.delete(); exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, dvalid, empty, full, count, ovf} !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_init got dout=%h dvalid=%b empty=%b full=%b count=%0d ovf=%b exp 00/0/1/0/0/0",
               dout, dvalid, empty, full, count, ovf);
    end
    step(1'b1, 8'h3c, 1'b0, 1'b0);
    step(1'b1, 8'h7e, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd2 || dout !== 8'h3c) begin
      failures++;
      $display("FAIL reset_prefill got count=%0d dout=%h exp 2/3c", count, dout);
    end
    // Asynchronous assertion well away from any clock edge.
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete(); exp_ovf = 1'b0;
    checks++;
    if ({dout, dvalid, empty, full, count} !== {8'h00, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_async got dout=%h dvalid=%b empty=%b full=%b count=%0d exp 00/0/1/0/0",
               dout, dvalid, empty, full, count);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (dvalid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL reset_no_pop got dvalid=%b count=%0d exp 0/0", dvalid, count);
    end
  endtask

  task automatic test_single();
    step(1'b1, 8'ha5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dvalid !== 1'b1 || dout !== 8'ha5) begin
        failures++;
        $display("FAIL single_hold[%0d] got dvalid=%b dout=%h exp 1/a5", i, dvalid, dout);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (dvalid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL single_pop got dvalid=%b count=%0d empty=%b exp 0/0/1", dvalid, count, empty);
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b0);
      if (i == 2) begin
        checks++;
        if (full !== 1'b0 || count !== 3'd3) begin
          failures++;
          $display("FAIL fill_3 got full=%b count=%0d exp 0/3", full, count);
        end
      end
      if (i >= 3) begin
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || dout !== 8'h11) begin
          failures++;
          $display("FAIL fill_full[%0d] got full=%b count=%0d dout=%h exp 1/4/11", i, full, count, dout);
        end
      end
    end
`ifdef OUTPORT_OVF_EN
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got %b exp 1", ovf);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got %b exp 0", ovf);
    end
    step(1'b1, 8'h66, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b1 || count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_set_wins got ovf=%b count=%0d exp 1/4", ovf, count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dvalid !== 1'b1 || dout !== vals[i]) begin
        failures++;
        $display("FAIL fill_drain[%0d] got dvalid=%b dout=%h exp 1/%h", i, dvalid, dout, vals[i]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      failures++;
      $display("FAIL fill_empty got empty=%b count=%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream [8];
    stream[0] = 8'h01; stream[1] = 8'h02;
    for (int i = 0; i < 6; i++) stream[i+2] = 8'h10 + 8'(i);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      checks++;
      if (count !== 3'd2 || dout !== stream[i+1]) begin
        failures++;
        $display("FAIL b2b[%0d] got count=%0d dout=%h exp 2/%h", i, count, dout, stream[i+1]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dout !== stream[i+6]) begin
        failures++;
        $display("FAIL b2b_tail[%0d] got %h exp %h", i, dout, stream[i+6]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      step(1'b1, b, 1'b0, 1'b0);
      checks++;
      if (dvalid !== 1'b1 || dout !== b || count !== 3'd1) begin
        failures++;
        $display("FAIL wrap_push[%0d] got dvalid=%b dout=%h count=%0d exp 1/%h/1", i, dvalid, dout, count, b);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (empty !== 1'b1 || dvalid !== 1'b0) begin
        failures++;
        $display("FAIL wrap_pop[%0d] got empty=%b dvalid=%b exp 1/0", i, empty, dvalid);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] second;
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    second = exp_q[1];
    step(1'b1, 8'hee, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd3 || full !== 1'b0 || dout !== second) begin
      failures++;
      $display("FAIL full_pop got count=%0d full=%b dout=%h exp 3/0/%h", count, full, dout, second);
    end
`ifdef OUTPORT_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_ovf got %b exp 1", ovf);
    end
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (count !== 3'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_drain got count=%0d ovf=%b exp 0/0", count, ovf);
    end
  endtask

  task automatic test_random();
    logic ol, dr, co;
    for (int i = 0; i < 400; i++) begin
      ol = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 45);
      co = ($urandom_range(0, 99) < 5);
      step(ol, 8'($urandom_range(0, 255)), dr, co);
      checks++;
      if (count !== 3'(exp_q.size()) || full !== (exp_q.size() == DEPTH) ||
          empty !== (exp_q.size() == 0) || dvalid !== (exp_q.size() != 0) ||
          ovf !== exp_ovf) begin
        failures++;
        $display("FAIL rand_status[%0d] got count=%0d full=%b empty=%b dvalid=%b ovf=%b exp count=%0d ovf=%b",
                 i, count, full, empty, dvalid, ovf, exp_q.size(), exp_ovf);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (dout !== exp_q[0]) begin
          failures++;
          $display("FAIL rand_dout[%0d] got %h exp %h", i, dout, exp_q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_full_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/out_port.md
# out_port

Output port on the 8-bit CPU datapath: the consumer of the accumulator value. When the controller executes an OUT instruction it pulses `outload`, and the block captures the AC output into a small FIFO. Queued bytes are then delivered to an external peripheral over a valid/ready handshake. `full` goes to the controller so it can stall OUT instructions while the queue cannot accept.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- AW, 2, pointer width; AW = log2(DEPTH)
- clk  input  1  clock; all state changes on posedge (the gated/selected CPU clock)
- rst  input  1  reset, asynchronous, active-low
- din  input  8  data from AC output
- outload  input  1  controller push strobe; sampled on posedge clk
- dout  output  8  head-of-queue byte to peripheral
- dvalid  output  1  dout holds a valid byte
- dready  input  1  peripheral accepts dout this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  AW+1  occupied entries, 0..DEPTH
- ovf  output  1  sticky overflow flag; only when OUTPORT_OVF_EN is defined
- clrovf  input  1  clears ovf; only when OUTPORT_OVF_EN is defined

## Operation
- **Storage.** DEPTH×8 register array, write pointer `wp`, read pointer `rp`, each AW bits, plus `count`.
- **Push.** Push = `outload && !full`.
  - `mem[wp] <= din`, `wp` increments.
  - `full` is evaluated from the registered count. A push when full is dropped even if a pop happens in the same cycle.
- **Pop.** Pop = `dvalid && dready`; `rp` increments.
- **Outputs.**
  - `dout = mem[rp]`, combinational from registers.
  - `dvalid = !empty`.
- **Count update.**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together (possible only when 0 < count < DEPTH): count unchanged, both pointers advance.
- **Pointer wrap.** Pointers wrap modulo DEPTH with no special case; DEPTH−1 goes to 0.
- **Ignored inputs.** `dready` while empty is ignored. `outload` while full is ignored: no state change apart from ovf.
- **Handshake rule.** Once `dvalid` is high, `dout` and `dvalid` stay stable until a pop. Pushes never alter the head entry.
- **Reset** (asynchronous, any time, including mid-transfer):
  - `wp`, `rp` and `count` go to 0.
  - All array entries go to 0.
  - `dout` = 0, `dvalid` = 0, `empty` = 1, `full` = 0, `ovf` = 0.
  - Any queued data is discarded.

## Timing
- Push-to-visible latency is 1 cycle. On an empty queue, an `outload` at edge N gives `dvalid` = 1 and `dout` = din after edge N.
- Pop takes effect at the edge where `dvalid && dready`. The next entry, if any, appears on `dout` immediately after that edge.
- Sustained throughput is 1 byte/cycle when `outload` and `dready` are both held high with 0 < count < DEPTH.
- `full`, `empty` and `count` are registered-derived and update at the same edge as the push/pop that changes them.

## Configuration
- **OUTPORT_OVF_EN defined:**
  - Adds the `ovf` and `clrovf` ports.
  - `ovf` is set at the edge where `outload && full`.
  - `clrovf` clears `ovf`. If set and clear occur in the same cycle, set wins.
  - `ovf` resets to 0.
- **OUTPORT_OVF_EN undefined:** the `ovf`/`clrovf` ports and logic are absent, and dropped pushes are silent.

## Test plan
- **Reset values:** assert rst=0 mid-run with 2 entries queued → `dout` = 0x00, `dvalid` = 0, `empty` = 1, `count` = 0 immediately (asynchronous). After release, first pop is impossible until a new push.
- **Single transfer:** push 0xA5 with dready=0 → `dvalid` high the next cycle with `dout` = 0xA5, held for 5 cycles. Raise dready for 1 cycle → `dvalid` = 0, `count` = 0.
- **Fill to full:** push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles with dready=0 → `full` = 1 after the 4th push, `count` = 4, 0x55 dropped. Drain order is 0x11, 0x22, 0x33, 0x44. With OUTPORT_OVF_EN, `ovf` = 1 until clrovf.
- **Simultaneous push/pop:** with count=2, hold outload=1 and dready=1 for 6 cycles, din incrementing from 0x10 → `count` stays 2 and `dout` sequence is in order with no loss.
- **Wrap-around:** 10 push/pop pairs through DEPTH=4 → pointers wrap twice and every byte is delivered exactly once, in order.
- **Full with pop:** at count=4, outload=1 and dready=1 in the same cycle → head popped, push dropped, `count` = 3.
